mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Full control unit for the multi-cycle RISC-V core: main FSM, ALU decoder and immediate-source decode in one block.
- Extends the base set (lw, sw, R-type, I-ALU, beq, jal) with jalr, lui, auipc, bne/blt/bge and xor. The extension set is gated by a parameter.
- Widens ImmSrc to 3 bits for U-type.
- Detects illegal encodings and parks the core in a trap state.

Parameters:
- EXT_ISA, 1: 1 enables jalr, lui, auipc, bne, blt, bge, xor/xori. With 0, those encodings are illegal.
- TRAP_STICKY, 1: 1 holds TRAP until reset. 0 leaves TRAP for FETCH after one cycle.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU result == 0
- Lt  in  1  ALU signed rs1 < rs2
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut to memory address
- MemWrite  out  1  data memory write
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 (A), 11 zero
- ALUSrcB  out  2  00 rs2 (B), 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- illegal  out  1  high while in TRAP

Behaviour:
- Reset:
  - State goes to FETCH on the next clk edge with reset=1. This applies mid-instruction too; no partial writes occur after that edge.
  - While reset is asserted, all enables (PCWrite, MemWrite, IRWrite, RegWrite) and illegal are forced to 0.
  - All select outputs are 0 during reset.
- Default per-state outputs are 0 unless listed below.
- ImmSrc:
  - Combinational from op in every state.
  - lw/I-ALU/jalr give 000, sw 001, branch 010, jal 011, lui/auipc 100.
  - Any other opcode gives 000.
- ALUOp (internal):
  - 00 selects add; 01 selects sub.
  - 10 decodes funct3:
    - 000: sub when op[5]&funct7b5, else add.
    - 010: slt. 100: xor (EXT_ISA only). 110: or. 111: and.
- States and actions:
  - FETCH: AdrSrc=0, IRWrite=1, A=PC, B=4, add, ResultSrc=10, PCWrite=1. Next is DECODE.
  - DECODE: A=OldPC, B=Imm, add (branch/jal target into ALUOut). Next state by op:
    - lw/sw go to MEMADR; R goes to EXECR; I-ALU goes to EXECI.
    - Branch goes to BRANCH; jal goes to JAL.
    - jalr, lui and auipc go to JALR, LUI and AUIPC respectively.
    - Anything else goes to TRAP.
  - Illegal in DECODE (goes to TRAP):
    - Unknown opcode.
    - Ext-only opcode with EXT_ISA=0.
    - Unsupported funct3 in R, I or branch.
    - funct7b5=1 in R-type with funct3≠000.
  - MEMADR: A=rs1, B=Imm, add. Next is MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next is MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next is FETCH.
  - EXECR: A=rs1, B=rs2, ALUOp=10. Next is ALUWB.
  - EXECI: A=rs1, B=Imm, ALUOp=10. Next is ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
  - BRANCH: A=rs1, B=rs2, sub, ResultSrc=00.
    - PCWrite = taken.
    - taken is Zero for beq, !Zero for bne, Lt for blt, !Lt for bge.
    - Next is FETCH.
  - JAL: A=OldPC, B=4, add, ResultSrc=00, PCWrite=1. Next is ALUWB.
  - JALR: A=rs1, B=Imm, add, ResultSrc=10, PCWrite=1. Next is JALRLINK.
  - JALRLINK: A=OldPC, B=4, add. Next is ALUWB.
  - LUI: A=zero, B=Imm, add. Next is ALUWB.
  - AUIPC: A=OldPC, B=Imm, add. Next is ALUWB.
  - TRAP: illegal=1 and all enables 0. Stays in TRAP (TRAP_STICKY=1) or goes to FETCH after one cycle (TRAP_STICKY=0).
- Cycles per instruction, FETCH through the final state: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui/auipc 4.
- Outputs are combinational from state, op and funct fields; there is no extra output register.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - ImmSrc, ALUControl, ResultSrc and ALUSrcA/B encodings.
- One sub-module, alu_decoder (ALUOp, funct3, op[5], funct7b5, EXT_ISA → ALUControl, bad_funct).
- The FSM, branch-taken logic and ImmSrc decode stay in mc_controller.

Test Plan:
- lw (op=0000011) after reset:
  - Visits FETCH→DECODE→MEMADR→MEMREAD→MEMWB.
  - IRWrite=1 only in cycle 1; RegWrite=1, ResultSrc=01 only in cycle 5; ImmSrc=000 throughout.
- R-type sub (funct3=000, funct7b5=1) → ALUControl=001 in EXECR, RegWrite in cycle 4; the same with funct7b5=0 → 000.
- Branch funct3=001 (bne):
  - Zero=0 → PCWrite=1 in BRANCH.
  - Zero=1 → PCWrite=0.
  - blt with Lt=1 → PCWrite=1.
- jalr (1100111) → ImmSrc=000, PCWrite=1 with ResultSrc=10 in cycle 3, ALUWB in cycle 5. lui (0110111) → ImmSrc=100, ALUSrcA=11.
- Illegal cases:
  - EXT_ISA=0 with op=0110111 → TRAP, illegal=1, enables 0 for 10 cycles (sticky). Reset → FETCH next edge.
  - TRAP_STICKY=0 → illegal pulses 1 cycle, then FETCH.
- Reset asserted in MEMWRITE cycle → no MemWrite on that edge; state=FETCH after it; all outputs 0 while reset=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit.
// Holds the controller state enum, the opcode constants the decoder
// recognises, and the encodings of every select bus the controller drives.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRLINK,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle.
// master: the control unit (takes instruction fields and ALU flags, drives
//         enables and selects).
// slave:  the datapath side (drives instruction fields and flags).
interface mc_ctrl_if;
    import mc_ctrl_pkg::*;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       Lt;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, Lt,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Lt,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal
    );

endinterface

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decoder.
// Ports: aluop (00 add, 01 sub, 10 decode funct3), funct3, op5 (instr[5],
// separates R-type from I-type), funct7b5 -> alucontrol, bad_funct.
// bad_funct flags a funct3/funct7b5 combination the ALU cannot execute and
// is evaluated independently of aluop so the FSM can use it in DECODE.
module alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol,
    output logic       bad_funct
);

    always_comb begin
        bad_funct = 1'b0;
        case (funct3)
            3'b000, 3'b010, 3'b110, 3'b111: bad_funct = 1'b0;
            3'b100:                         bad_funct = !EXT_ISA;
            default:                        bad_funct = 1'b1;
        endcase
        // only add/sub carries a funct7 variant in R-type
        if (op5 && funct7b5 && (funct3 != 3'b000)) begin
            bad_funct = 1'b1;
        end
    end

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b100:  alucontrol = EXT_ISA ? ALU_XOR : ALU_ADD;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Control unit for the multi-cycle RISC-V core: main FSM, branch-taken
// logic and ImmSrc decode, with the ALU decoder as a sub-block.
// Ports: clk, reset (synchronous, active-high), bus (mc_ctrl_if.master:
// instruction fields and ALU flags in, enables/selects/illegal out).
// Outputs are combinational from state and instruction fields; while reset
// is high every output is held at 0.
//
// state      | meaning
// -----------+-----------------------------------------------
// FETCH      | read instr at PC, PC <= PC+4
// DECODE     | ALUOut <= OldPC+Imm, pick path, catch illegal
// MEMADR     | ALUOut <= rs1+Imm
// MEMREAD    | read memory at ALUOut
// MEMWB      | rd <= Data
// MEMWRITE   | write memory at ALUOut
// EXECR      | ALUOut <= rs1 op rs2
// EXECI      | ALUOut <= rs1 op Imm
// ALUWB      | rd <= ALUOut
// BRANCH     | compare rs1/rs2, PC <= ALUOut if taken
// JAL        | PC <= ALUOut, ALUOut <= OldPC+4
// JALR       | PC <= rs1+Imm
// JALRLINK   | ALUOut <= OldPC+4
// LUI        | ALUOut <= 0+Imm
// AUIPC      | ALUOut <= OldPC+Imm
// TRAP       | illegal instruction, all enables off
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter bit EXT_ISA     = 1'b1,
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    mc_ctrl_if.master  bus
);

    state_t     state, state_n, decode_next;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] alu_control, imm_src;
    logic       bad_funct, br_ok, br_taken;

    alu_decoder #(.EXT_ISA(EXT_ISA)) u_alu_dec (
        .aluop      (alu_op),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .alucontrol (alu_control),
        .bad_funct  (bad_funct)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        imm_src = IMM_I;
        case (bus.op)
            OP_SW:            imm_src = IMM_S;
            OP_BR:            imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

    always_comb begin
        br_ok    = 1'b0;
        br_taken = 1'b0;
        case (bus.funct3)
            3'b000: begin br_ok = 1'b1;    br_taken = bus.Zero;  end
            3'b001: begin br_ok = EXT_ISA; br_taken = !bus.Zero; end
            3'b100: begin br_ok = EXT_ISA; br_taken = bus.Lt;    end
            3'b101: begin br_ok = EXT_ISA; br_taken = !bus.Lt;   end
            default: begin br_ok = 1'b0;   br_taken = 1'b0;      end
        endcase
    end

    always_comb begin
        decode_next = S_TRAP;
        case (bus.op)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_R:         decode_next = bad_funct ? S_TRAP : S_EXECR;
            OP_I:         decode_next = bad_funct ? S_TRAP : S_EXECI;
            OP_BR:        decode_next = br_ok ? S_BRANCH : S_TRAP;
            OP_JAL:       decode_next = S_JAL;
            OP_JALR:      decode_next = EXT_ISA ? S_JALR : S_TRAP;
            OP_LUI:       decode_next = EXT_ISA ? S_LUI : S_TRAP;
            OP_AUIPC:     decode_next = EXT_ISA ? S_AUIPC : S_TRAP;
            default:      decode_next = S_TRAP;
        endcase
    end

    always_comb begin
        state_n    = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        trap       = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_n    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_n   = decode_next;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_n   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_n   = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
                state_n   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_n   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_n   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                pc_write  = br_taken;
                state_n   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_n   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                pc_write   = 1'b1;
                state_n    = S_JALRLINK;
            end
            S_JALRLINK: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                state_n   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                state_n   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_n   = S_ALUWB;
            end
            S_TRAP: begin
                trap    = 1'b1;
                state_n = TRAP_STICKY ? S_TRAP : S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

    // reset masks everything so an interrupted instruction cannot write
    assign bus.PCWrite    = !reset && pc_write;
    assign bus.AdrSrc     = !reset && adr_src;
    assign bus.MemWrite   = !reset && mem_write;
    assign bus.IRWrite    = !reset && ir_write;
    assign bus.RegWrite   = !reset && reg_write;
    assign bus.illegal    = !reset && trap;
    assign bus.ResultSrc  = reset ? 2'b00 : result_src;
    assign bus.ALUSrcA    = reset ? 2'b00 : alu_src_a;
    assign bus.ALUSrcB    = reset ? 2'b00 : alu_src_b;
    assign bus.ALUControl = reset ? 3'b000 : alu_control;
    assign bus.ImmSrc     = reset ? 3'b000 : imm_src;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller. Three instances cover the parameter
// corners (full ISA sticky trap, base ISA sticky trap, full ISA one-cycle
// trap); one is active at a time while the others sit in reset.
module tb_mc_controller;

    localparam logic [6:0] M_LW = 7'h03, M_SW = 7'h23, M_R = 7'h33, M_I = 7'h13,
                           M_BR = 7'h63, M_JAL = 7'h6f, M_JALR = 7'h67,
                           M_LUI = 7'h37, M_AUIPC = 7'h17;

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res, srca, srcb;
        logic [2:0] aluc, imm;
        logic       ill;
    } outs_t;

    typedef struct {
        outs_t v;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic [6:0] op_s = '0;
    logic [2:0] f3_s = '0;
    logic       f7_s = 1'b0, z_s = 1'b0, lt_s = 1'b0;

    mc_ctrl_if if_a ();
    mc_ctrl_if if_b ();
    mc_ctrl_if if_c ();

    assign if_a.op = op_s; assign if_a.funct3 = f3_s; assign if_a.funct7b5 = f7_s;
    assign if_a.Zero = z_s; assign if_a.Lt = lt_s;
    assign if_b.op = op_s; assign if_b.funct3 = f3_s; assign if_b.funct7b5 = f7_s;
    assign if_b.Zero = z_s; assign if_b.Lt = lt_s;
    assign if_c.op = op_s; assign if_c.funct3 = f3_s; assign if_c.funct7b5 = f7_s;
    assign if_c.Zero = z_s; assign if_c.Lt = lt_s;

    mc_controller #(.EXT_ISA(1'b1), .TRAP_STICKY(1'b1)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a.master));
    mc_controller #(.EXT_ISA(1'b0), .TRAP_STICKY(1'b1)) dut_b (.clk(clk), .reset(rst_b), .bus(if_b.master));
    mc_controller #(.EXT_ISA(1'b1), .TRAP_STICKY(1'b0)) dut_c (.clk(clk), .reset(rst_c), .bus(if_c.master));

    int    sel = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    exp_t  q[$];
    outs_t act;

    always_comb begin
        act = '0;
        case (sel)
            0: act = {if_a.PCWrite, if_a.AdrSrc, if_a.MemWrite, if_a.IRWrite, if_a.RegWrite,
                      if_a.ResultSrc, if_a.ALUSrcA, if_a.ALUSrcB, if_a.ALUControl, if_a.ImmSrc, if_a.illegal};
            1: act = {if_b.PCWrite, if_b.AdrSrc, if_b.MemWrite, if_b.IRWrite, if_b.RegWrite,
                      if_b.ResultSrc, if_b.ALUSrcA, if_b.ALUSrcB, if_b.ALUControl, if_b.ImmSrc, if_b.illegal};
            default: act = {if_c.PCWrite, if_c.AdrSrc, if_c.MemWrite, if_c.IRWrite, if_c.RegWrite,
                      if_c.ResultSrc, if_c.ALUSrcA, if_c.ALUSrcB, if_c.ALUControl, if_c.ImmSrc, if_c.illegal};
        endcase
    end

    // monitor: the controller presents a full output vector every cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got pcw%b adr%b mw%b irw%b rw%b res%b a%b b%b alu%b imm%b ill%b, expected pcw%b adr%b mw%b irw%b rw%b res%b a%b b%b alu%b imm%b ill%b",
                         e.tag, act.pcw, act.adr, act.memw, act.irw, act.regw, act.res, act.srca,
                         act.srcb, act.aluc, act.imm, act.ill, e.v.pcw, e.v.adr, e.v.memw, e.v.irw,
                         e.v.regw, e.v.res, e.v.srca, e.v.srcb, e.v.aluc, e.v.imm, e.v.ill);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [2:0] m_imm(logic [6:0] op);
        if (op == M_SW) return 3'b001;
        if (op == M_BR) return 3'b010;
        if (op == M_JAL) return 3'b011;
        if (op == M_LUI || op == M_AUIPC) return 3'b100;
        return 3'b000;
    endfunction

    function automatic bit m_alu_ok(logic [2:0] f3, bit ext);
        return (f3 == 0) || (f3 == 2) || (f3 == 6) || (f3 == 7) || (ext && f3 == 4);
    endfunction

    function automatic bit m_legal(logic [6:0] op, logic [2:0] f3, logic f7, bit ext);
        if (op == M_LW || op == M_SW || op == M_JAL) return 1;
        if (op == M_R) return m_alu_ok(f3, ext) && !(f7 && f3 != 0);
        if (op == M_I) return m_alu_ok(f3, ext);
        if (op == M_BR) return (f3 == 0) || (ext && (f3 == 1 || f3 == 4 || f3 == 5));
        if (op == M_JALR || op == M_LUI || op == M_AUIPC) return ext;
        return 0;
    endfunction

    function automatic int m_len(logic [6:0] op);
        if (op == M_LW || op == M_JALR) return 5;
        if (op == M_BR) return 3;
        return 4;
    endfunction

    function automatic logic [2:0] m_alu(logic [6:0] op, logic [2:0] f3, logic f7);
        case (f3)
            3'd0: return (op == M_R && f7) ? 3'b001 : 3'b000;
            3'd2: return 3'b101;
            3'd4: return 3'b100;
            3'd6: return 3'b011;
            3'd7: return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // expected outputs of cycle k (0 = FETCH) of a legal instruction
    function automatic outs_t m_out(int k, logic [6:0] op, logic [2:0] f3, logic f7, logic z, logic lt);
        outs_t o;
        bit taken;
        o = '0;
        o.imm = m_imm(op);
        if (k == 0) begin
            o.pcw = 1; o.irw = 1; o.res = 2'b10; o.srcb = 2'b10;
        end else if (k == 1) begin
            o.srca = 2'b01; o.srcb = 2'b01;
        end else if (op == M_LW || op == M_SW) begin
            if (k == 2) begin o.srca = 2'b10; o.srcb = 2'b01; end
            else if (op == M_SW) begin o.adr = 1; o.memw = 1; end
            else if (k == 3) o.adr = 1;
            else begin o.res = 2'b01; o.regw = 1; end
        end else if (op == M_BR) begin
            case (f3)
                3'd0: taken = z;
                3'd1: taken = !z;
                3'd4: taken = lt;
                default: taken = !lt;
            endcase
            o.srca = 2'b10; o.aluc = 3'b001; o.pcw = taken;
        end else if (k == m_len(op) - 1) begin
            o.regw = 1;
        end else if (op == M_R) begin
            o.srca = 2'b10; o.aluc = m_alu(op, f3, f7);
        end else if (op == M_I) begin
            o.srca = 2'b10; o.srcb = 2'b01; o.aluc = m_alu(op, f3, f7);
        end else if (op == M_JAL) begin
            o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1;
        end else if (op == M_JALR) begin
            if (k == 2) begin o.srca = 2'b10; o.srcb = 2'b01; o.res = 2'b10; o.pcw = 1; end
            else begin o.srca = 2'b01; o.srcb = 2'b10; end
        end else if (op == M_LUI) begin
            o.srca = 2'b11; o.srcb = 2'b01;
        end else begin
            o.srca = 2'b01; o.srcb = 2'b01;
        end
        return o;
    endfunction

    // ---------------- stimulus ----------------
    task automatic push(outs_t v, string tag);
        exp_t e;
        e.v = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic set_rst(int dut, logic v);
        rst_a = (dut == 0) ? v : 1'b1;
        rst_b = (dut == 1) ? v : 1'b1;
        rst_c = (dut == 2) ? v : 1'b1;
    endtask

    task automatic do_reset(int dut);
        @(posedge clk); #1;
        sel = dut;
        set_rst(dut, 1'b1);
        op_s = 7'($urandom); f3_s = 3'($urandom); f7_s = 1'($urandom);
        z_s = 1'($urandom); lt_s = 1'($urandom);
        push('0, $sformatf("dut%0d reset", dut));
    endtask

    // zf/lf: -1 random, else forced value; abort_at: cycle in which reset is raised
    task automatic run_instr(int dut, logic [6:0] op, logic [2:0] f3, logic f7,
                             int zf, int lf, int abort_at, int trap_cycles);
        bit    ext, sticky, legal;
        int    len;
        outs_t o;
        ext    = (dut != 1);
        sticky = (dut != 2);
        legal  = m_legal(op, f3, f7, ext);
        len    = legal ? m_len(op) : 2 + (sticky ? trap_cycles : 1);
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            op_s = op; f3_s = f3; f7_s = f7;
            z_s  = (zf < 0) ? 1'($urandom) : zf[0];
            lt_s = (lf < 0) ? 1'($urandom) : lf[0];
            if (k == abort_at) begin
                set_rst(dut, 1'b1);
                push('0, $sformatf("dut%0d op=%b f3=%b reset in cycle %0d", dut, op, f3, k + 1));
                return;
            end
            set_rst(dut, 1'b0);
            if (legal || k < 2) begin
                o = m_out(k, op, f3, f7, z_s, lt_s);
            end else begin
                o = '0;
                o.imm = m_imm(op);
                o.ill = 1'b1;
            end
            push(o, $sformatf("dut%0d op=%b f3=%b f7=%b z=%b lt=%b cycle %0d",
                              dut, op, f3, f7, z_s, lt_s, k + 1));
        end
        if (!legal && sticky) do_reset(dut);
    endtask

    logic [6:0] pool [9] = '{M_LW, M_SW, M_R, M_I, M_BR, M_JAL, M_JALR, M_LUI, M_AUIPC};

    task automatic random_run(int dut, int n);
        logic [6:0] op;
        int idx, ab;
        for (int i = 0; i < n; i++) begin
            idx = $urandom_range(0, 9);
            op  = (idx == 9) ? 7'($urandom) : pool[idx];
            ab  = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(dut, op, 3'($urandom), ($urandom_range(0, 3) == 0), -1, -1, ab,
                      $urandom_range(1, 4));
        end
    endtask

    initial begin
        // full ISA, sticky trap
        do_reset(0);
        do_reset(0);
        run_instr(0, M_LW, 3'b010, 1'b0, -1, -1, -1, 1);
        run_instr(0, M_R, 3'b000, 1'b1, -1, -1, -1, 1);
        run_instr(0, M_R, 3'b000, 1'b0, -1, -1, -1, 1);
        run_instr(0, M_BR, 3'b001, 1'b0, 0, -1, -1, 1);
        run_instr(0, M_BR, 3'b001, 1'b0, 1, -1, -1, 1);
        run_instr(0, M_BR, 3'b100, 1'b0, -1, 1, -1, 1);
        run_instr(0, M_JALR, 3'b000, 1'b0, -1, -1, -1, 1);
        run_instr(0, M_LUI, 3'b101, 1'b0, -1, -1, -1, 1);
        run_instr(0, M_I, 3'b100, 1'b1, -1, -1, -1, 1);
        run_instr(0, M_SW, 3'b010, 1'b0, -1, -1, 3, 1);
        run_instr(0, M_JAL, 3'b000, 1'b0, -1, -1, -1, 1);
        run_instr(0, M_R, 3'b110, 1'b1, -1, -1, -1, 3);
        random_run(0, 150);

        // base ISA, sticky trap
        do_reset(1);
        run_instr(1, M_LUI, 3'b000, 1'b0, -1, -1, -1, 10);
        run_instr(1, M_LW, 3'b010, 1'b0, -1, -1, -1, 1);
        run_instr(1, M_BR, 3'b001, 1'b0, 0, -1, -1, 2);
        run_instr(1, M_R, 3'b100, 1'b0, -1, -1, -1, 2);
        random_run(1, 80);

        // full ISA, one-cycle trap
        do_reset(2);
        run_instr(2, 7'h7f, 3'b000, 1'b0, -1, -1, -1, 1);
        run_instr(2, M_LW, 3'b010, 1'b0, -1, -1, -1, 1);
        run_instr(2, M_BR, 3'b011, 1'b0, -1, -1, -1, 1);
        run_instr(2, M_AUIPC, 3'b000, 1'b0, -1, -1, -1, 1);
        random_run(2, 80);

        @(posedge clk); #1;
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
